// File: rtl/multiplier_taint_track_nbit_if.sv
`default_nettype none
// ============================================================================
// Module   : multiplier_taint_track_nbit_if
// Brief    : Request/response bundle for the taint-tracking multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface multiplier_taint_track_nbit_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic                   sgn;
    logic [WIDTH-1:0]       multiplier;
    logic [WIDTH-1:0]       multiplicand;
    logic                   start_t;
    logic [WIDTH-1:0]       multiplier_t;
    logic [WIDTH-1:0]       multiplicand_t;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;
    logic [2*WIDTH-1:0]     product_t;

    modport master (
        output start, sgn, multiplier, multiplicand,
        output start_t, multiplier_t, multiplicand_t,
        input  busy, done, product, product_t
    );

    modport slave (
        input  start, sgn, multiplier, multiplicand,
        input  start_t, multiplier_t, multiplicand_t,
        output busy, done, product, product_t
    );
endinterface
`default_nettype wire

// File: rtl/multiplier_taint_track_nbit.sv
`default_nettype none
// ============================================================================
// Module   : multiplier_taint_track_nbit
// Brief    : Shift-add sequential multiplier with per-bit conservative taint.
// Revision : 1.0 - initial release
// ============================================================================
module multiplier_taint_track_nbit #(
    parameter int WIDTH = 8
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    multiplier_taint_track_nbit_if.slave     bus
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q, b_q, at_q, bt_q;
    logic               neg_q, ctl_t_q;
    logic [PW-1:0]      acc_q, acc_t_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q, done_q;
    logic [PW-1:0]      product_q, product_t_q;

    logic [WIDTH-1:0]   a_mag, b_mag, a_sh, at_sh;
    logic               a_bit, at_bit;
    logic [PW-1:0]      pp, pp_t, taint_or;
    logic [PW-1:0]      acc_d, acc_t_d, product_d, product_t_d;

    always_comb begin
        a_mag = (bus.sgn && bus.multiplier[WIDTH-1])   ? -bus.multiplier   : bus.multiplier;
        b_mag = (bus.sgn && bus.multiplicand[WIDTH-1]) ? -bus.multiplicand : bus.multiplicand;

        a_sh   = a_q  >> cnt_q;
        at_sh  = at_q >> cnt_q;
        a_bit  = a_sh[0];
        at_bit = at_sh[0];

        pp = a_bit ? ({{WIDTH{1'b0}}, b_q} << cnt_q) : '0;
        if (at_bit)
            pp_t = {PW{1'b1}} << cnt_q;
        else if (a_bit)
            pp_t = {{WIDTH{1'b0}}, bt_q} << cnt_q;
        else
            pp_t = '0;

        acc_d = acc_q + pp;
        // x | -x sets every bit at and above the lowest set bit of x.
        taint_or = acc_t_q | pp_t;
        acc_t_d  = taint_or | (-taint_or);

        product_d = neg_q ? -acc_d : acc_d;
        if (ctl_t_q)
            product_t_d = {PW{1'b1}};
        else if (neg_q)
            product_t_d = acc_t_d | (-acc_t_d);
        else
            product_t_d = acc_t_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            at_q        <= '0;
            bt_q        <= '0;
            neg_q       <= 1'b0;
            ctl_t_q     <= 1'b0;
            acc_q       <= '0;
            acc_t_q     <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            product_q   <= '0;
            product_t_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        a_q     <= bus.sgn ? a_mag : bus.multiplier;
                        b_q     <= bus.sgn ? b_mag : bus.multiplicand;
                        at_q    <= bus.multiplier_t;
                        bt_q    <= bus.multiplicand_t;
                        neg_q   <= bus.sgn & (bus.multiplier[WIDTH-1] ^ bus.multiplicand[WIDTH-1]);
                        ctl_t_q <= bus.start_t |
                                   (bus.sgn & (bus.multiplier_t[WIDTH-1] | bus.multiplicand_t[WIDTH-1]));
                        acc_q   <= '0;
                        acc_t_q <= '0;
                        cnt_q   <= '0;
                    end
                end
                S_RUN: begin
                    acc_q   <= acc_d;
                    acc_t_q <= acc_t_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        product_q   <= product_d;
                        product_t_q <= product_t_d;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.product   = product_q;
    assign bus.product_t = product_t_q;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_taint_track_nbit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiplier_taint_track_nbit
// Brief    : Directed self-checking bench for the taint-tracking multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiplier_taint_track_nbit;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    multiplier_taint_track_nbit_if #(.WIDTH(8)) if8 ();
    multiplier_taint_track_nbit_if #(.WIDTH(7)) if7 ();

    multiplier_taint_track_nbit #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    multiplier_taint_track_nbit #(.WIDTH(7)) dut7 (.clk(clk), .rst(rst), .bus(if7));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic st, input logic [7:0] at, input logic [7:0] bt,
                        output logic [15:0] p, output logic [15:0] pt, output int lat);
        if8.multiplier = a;  if8.multiplicand = b;  if8.sgn = s;
        if8.start_t = st;    if8.multiplier_t = at; if8.multiplicand_t = bt;
        if8.start = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (if8.done) begin
                lat = k;
                break;
            end
        end
        p  = if8.product;
        pt = if8.product_t;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        #12;
        tests++; if (if8.busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b want 0", if8.busy); end
        tests++; if (if8.done !== 1'b0) begin fails++; $display("FAIL reset done: got %b want 0", if8.done); end
        tests++; if (if8.product !== 16'h0) begin fails++; $display("FAIL reset product: got %h want 0000", if8.product); end
        tests++; if (if8.product_t !== 16'h0) begin fails++; $display("FAIL reset product_t: got %h want 0000", if8.product_t); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned;
        logic [15:0] p, pt;
        int lat;
        run8(8'd15, 8'd15, 1'b0, 1'b0, 8'h00, 8'h00, p, pt, lat);
        tests++; if (lat !== 8) begin fails++; $display("FAIL u15x15 latency: got %0d want 8", lat); end
        tests++; if (p !== 16'd225) begin fails++; $display("FAIL u15x15 product: got %0d want 225", p); end
        tests++; if (pt !== 16'h0) begin fails++; $display("FAIL u15x15 product_t: got %h want 0000", pt); end
        run8(8'd92, 8'd75, 1'b0, 1'b0, 8'h00, 8'h00, p, pt, lat);
        tests++; if (p !== 16'd6900) begin fails++; $display("FAIL u92x75 product: got %0d want 6900", p); end
        run8(8'd0, 8'd12, 1'b0, 1'b0, 8'h00, 8'h00, p, pt, lat);
        tests++; if (lat !== 8) begin fails++; $display("FAIL u0x12 latency: got %0d want 8", lat); end
        tests++; if (p !== 16'd0) begin fails++; $display("FAIL u0x12 product: got %0d want 0", p); end
    endtask

    task automatic test_signed;
        logic [15:0] p, pt;
        int lat;
        run8(8'hFD, 8'd5, 1'b1, 1'b0, 8'h00, 8'h00, p, pt, lat);
        tests++; if (p !== 16'hFFF1) begin fails++; $display("FAIL s-3x5 product: got %h want fff1", p); end
        tests++; if (pt !== 16'h0) begin fails++; $display("FAIL s-3x5 product_t: got %h want 0000", pt); end
        run8(8'h80, 8'h80, 1'b1, 1'b0, 8'h00, 8'h00, p, pt, lat);
        tests++; if (p !== 16'h4000) begin fails++; $display("FAIL s-128x-128 product: got %h want 4000", p); end
        tests++; if (pt !== 16'h0) begin fails++; $display("FAIL s-128x-128 product_t: got %h want 0000", pt); end
        run8(8'd127, 8'hFF, 1'b1, 1'b0, 8'h00, 8'h00, p, pt, lat);
        tests++; if (p !== 16'hFF81) begin fails++; $display("FAIL s127x-1 product: got %h want ff81", p); end
        tests++; if (pt !== 16'h0) begin fails++; $display("FAIL s127x-1 product_t: got %h want 0000", pt); end
    endtask

    task automatic test_bit_taint;
        logic [15:0] p, pt;
        int lat;
        run8(8'd4, 8'd5, 1'b0, 1'b0, 8'h00, 8'h01, p, pt, lat);
        tests++; if (p !== 16'd20) begin fails++; $display("FAIL taintB product: got %0d want 20", p); end
        tests++; if (pt !== 16'hFFFC) begin fails++; $display("FAIL taintB product_t: got %h want fffc", pt); end
        run8(8'd0, 8'd5, 1'b0, 1'b0, 8'h80, 8'h00, p, pt, lat);
        tests++; if (p !== 16'd0) begin fails++; $display("FAIL taintA product: got %0d want 0", p); end
        tests++; if (pt !== 16'hFF80) begin fails++; $display("FAIL taintA product_t: got %h want ff80", pt); end
    endtask

    task automatic test_ctl_taint;
        logic [15:0] p, pt;
        int lat;
        run8(8'd1, 8'd2, 1'b0, 1'b1, 8'h00, 8'h00, p, pt, lat);
        tests++; if (p !== 16'd2) begin fails++; $display("FAIL ctl start_t product: got %0d want 2", p); end
        tests++; if (pt !== 16'hFFFF) begin fails++; $display("FAIL ctl start_t product_t: got %h want ffff", pt); end
        run8(8'd3, 8'd2, 1'b1, 1'b0, 8'h00, 8'h80, p, pt, lat);
        tests++; if (p !== 16'd6) begin fails++; $display("FAIL ctl sign product: got %0d want 6", p); end
        tests++; if (pt !== 16'hFFFF) begin fails++; $display("FAIL ctl sign product_t: got %h want ffff", pt); end
    endtask

    task automatic test_start_ignored;
        int lat;
        if8.multiplier = 8'd3; if8.multiplicand = 8'd4; if8.sgn = 1'b0;
        if8.start_t = 1'b0; if8.multiplier_t = 8'h00; if8.multiplicand_t = 8'h00;
        if8.start = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if8.multiplier = 8'd9; if8.multiplicand = 8'd9; if8.start = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        lat = -1;
        for (int k = 4; k <= 40; k++) begin
            @(posedge clk); #1;
            if (if8.done) begin
                lat = k;
                break;
            end
        end
        tests++; if (lat !== 8) begin fails++; $display("FAIL ignore latency: got %0d want 8", lat); end
        tests++; if (if8.product !== 16'd12) begin fails++; $display("FAIL ignore product: got %0d want 12", if8.product); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int c1, c2;
        logic [15:0] p1;
        c1 = -1; c2 = -1; p1 = '0;
        if8.multiplier = 8'd2; if8.multiplicand = 8'd3; if8.sgn = 1'b0;
        if8.start_t = 1'b0; if8.multiplier_t = 8'h00; if8.multiplicand_t = 8'h00;
        if8.start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (if8.done) begin
                if (c1 < 0) begin c1 = k; p1 = if8.product; end
                else if (c2 < 0) c2 = k;
            end
        end
        if8.start = 1'b0;
        tests++; if (c1 < 0 || c2 < 0 || (c2 - c1) !== 10) begin fails++; $display("FAIL b2b spacing: got %0d/%0d want 10 apart", c1, c2); end
        tests++; if (p1 !== 16'd6) begin fails++; $display("FAIL b2b product: got %0d want 6", p1); end
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midrun;
        logic [15:0] p, pt;
        int lat, seen;
        if8.multiplier = 8'd15; if8.multiplicand = 8'd15; if8.sgn = 1'b0;
        if8.start_t = 1'b1; if8.multiplier_t = 8'h00; if8.multiplicand_t = 8'h00;
        if8.start = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0; if8.start_t = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        tests++; if (if8.busy !== 1'b0) begin fails++; $display("FAIL midrun busy: got %b want 0", if8.busy); end
        tests++; if (if8.done !== 1'b0) begin fails++; $display("FAIL midrun done: got %b want 0", if8.done); end
        tests++; if (if8.product !== 16'h0) begin fails++; $display("FAIL midrun product: got %h want 0000", if8.product); end
        tests++; if (if8.product_t !== 16'h0) begin fails++; $display("FAIL midrun product_t: got %h want 0000", if8.product_t); end
        #3;
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (if8.done) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL midrun stray done: got %0d want 0", seen); end
        run8(8'd6, 8'd7, 1'b0, 1'b0, 8'h00, 8'h00, p, pt, lat);
        tests++; if (p !== 16'd42 || lat !== 8) begin fails++; $display("FAIL post-reset run: got %0d lat %0d want 42 lat 8", p, lat); end
    endtask

    task automatic test_width7;
        int lat;
        if7.multiplier = 7'd42; if7.multiplicand = 7'd78; if7.sgn = 1'b0;
        if7.start_t = 1'b0; if7.multiplier_t = 7'h00; if7.multiplicand_t = 7'h00;
        if7.start = 1'b1;
        @(posedge clk); #1;
        if7.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (if7.done) begin
                lat = k;
                break;
            end
        end
        tests++; if (lat !== 7) begin fails++; $display("FAIL w7 latency: got %0d want 7", lat); end
        tests++; if (if7.product !== 14'd3276) begin fails++; $display("FAIL w7 product: got %0d want 3276", if7.product); end
        tests++; if (if7.product_t !== 14'h0) begin fails++; $display("FAIL w7 product_t: got %h want 0000", if7.product_t); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        if8.start = 1'b0; if8.sgn = 1'b0; if8.multiplier = '0; if8.multiplicand = '0;
        if8.start_t = 1'b0; if8.multiplier_t = '0; if8.multiplicand_t = '0;
        if7.start = 1'b0; if7.sgn = 1'b0; if7.multiplier = '0; if7.multiplicand = '0;
        if7.start_t = 1'b0; if7.multiplier_t = '0; if7.multiplicand_t = '0;

        test_reset;
        test_unsigned;
        test_signed;
        test_bit_taint;
        test_ctl_taint;
        test_start_ignored;
        test_back_to_back;
        test_ctl_taint;
        test_reset_midrun;
        test_width7;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
